// File: rtl/mem_access_unit.sv
// Load/store unit: one pipeline request at a time, one bus access, extended load data or fault code back.
// Latency accept->resp_valid is 2 cycles with immediate ack (1 on fault); in_ready only while idle, response never stalls.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  mem_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_fault
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSV   = 2'b11;

  localparam logic [2:0] SEL_BS = 3'b001;
  localparam logic [2:0] SEL_HS = 3'b010;
  localparam logic [2:0] SEL_W  = 3'b011;
  localparam logic [2:0] SEL_BU = 3'b100;
  localparam logic [2:0] SEL_HU = 3'b101;

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_MIS  = 2'b01;
  localparam logic [1:0] F_ILL  = 2'b10;
  localparam logic [1:0] F_TMO  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      sel_q, sel_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]      bus_wstrb_q, bus_wstrb_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic [1:0]      resp_fault_q, resp_fault_d;

  logic        is_byte, is_half, is_word, illegal, misaligned, is_store;
  logic [1:0]  fault_in;
  logic [3:0]  strb_in;
  logic [31:0] wdata_rep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request decode; unsigned selects on a store behave as the signed width.
  always_comb begin
    is_byte    = (mem_sel == SEL_BS) || (mem_sel == SEL_BU);
    is_half    = (mem_sel == SEL_HS) || (mem_sel == SEL_HU);
    is_word    = (mem_sel == SEL_W);
    is_store   = (mem_op == OP_STORE);
    illegal    = (mem_op == OP_RSV) || !(is_byte || is_half || is_word);
    misaligned = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    fault_in   = illegal ? F_ILL : (misaligned ? F_MIS : F_NONE);
    strb_in    = 4'b0000;
    wdata_rep  = wdata;
    if (is_byte) begin
      strb_in   = 4'b0001 << addr[1:0];
      wdata_rep = {4{wdata[7:0]}};
    end else if (is_half) begin
      strb_in   = addr[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata[15:0]}};
    end else if (is_word) begin
      strb_in   = 4'b1111;
    end
    if (!is_store) begin
      strb_in   = 4'b0000;
      wdata_rep = '0;
    end
  end

  always_comb begin
    ld_byte = bus_rdata[{addr_lo_q, 3'b000} +: 8];
    ld_half = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (sel_q)
      SEL_BS:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      SEL_BU:  ld_ext = {24'd0, ld_byte};
      SEL_HS:  ld_ext = {{16{ld_half[15]}}, ld_half};
      SEL_HU:  ld_ext = {16'd0, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    addr_lo_d    = addr_lo_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_fault_d = F_NONE;
    case (state_q)
      IDLE: begin
        if (in_valid && (mem_op != OP_NOP)) begin
          sel_d     = mem_sel;
          addr_lo_d = addr[1:0];
          if (fault_in != F_NONE) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = fault_in;
          end else begin
            state_d     = BUS;
            cnt_d       = CW'(1);
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = wdata_rep;
            bus_wstrb_d = strb_in;
          end
        end
      end
      BUS: begin
        if (bus_ack || (cnt_q == CNT_MAX)) begin
          state_d      = RESP;
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          // An ack arriving on the last allowed cycle still completes cleanly.
          if (bus_ack) begin
            resp_rdata_d = bus_we_q ? 32'd0 : ld_ext;
          end else begin
            resp_fault_d = F_TMO;
          end
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      addr_lo_q    <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      addr_lo_q    <= addr_lo_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: the driver pushes expected bus and response records, a bus responder and a response monitor check them.
module tb_mem_access_unit;
  localparam int TO = 4;

  typedef struct {
    logic        legal;
    logic [31:0] baddr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] bwdata;
    int          delay;
    logic [31:0] rdata_mem;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_fault;
    int          lat;
    int          runlen;
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          at_cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  mem_op;
  logic [2:0]  mem_sel;
  logic [31:0] addr, wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    k_bus = 0;
  logic  rsp_active = 1'b0;
  txn_t  cur;
  txn_t  bus_q[$];
  resp_t resp_q[$];

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mem_op(mem_op), .mem_sel(mem_sel), .addr(addr), .wdata(wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: width in bytes, lane offset, then masking/shifting on plain integers.
  function automatic txn_t model(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] a,
                                 input logic [31:0] wd, input int d, input logic [31:0] mem);
    txn_t t;
    int w, off;
    logic [63:0] mask, v;
    t = '{default: '0};
    t.delay = d;
    t.rdata_mem = mem;
    case (sel)
      3'd1, 3'd4: w = 1;
      3'd2, 3'd5: w = 2;
      3'd3:       w = 4;
      default:    w = 0;
    endcase
    off = int'(a[1:0]);
    if (op == 2'b11 || w == 0) begin t.exp_fault = 2'b10; return t; end
    if (off % w != 0) begin t.exp_fault = 2'b01; return t; end
    t.legal = 1'b1;
    t.baddr = a - 32'(off);
    t.we = (op == 2'b10);
    mask = (64'd1 << (8 * w)) - 64'd1;
    if (t.we) begin
      t.strb = 4'(((1 << w) - 1) << off);
      for (int i = 0; i < 4; i++) t.bwdata[8*i +: 8] = wd[8*(i % w) +: 8];
    end
    if (d >= TO) begin
      t.exp_fault = 2'b11;
      t.lat = TO;
      t.runlen = TO;
    end else begin
      t.lat = d + 1;
      t.runlen = d + 1;
      if (!t.we) begin
        v = ({32'd0, mem} >> (8 * off)) & mask;
        if ((sel == 3'd1 || sel == 3'd2) && v[8*w-1]) v = v | ~mask;
        t.exp_rdata = v[31:0];
      end
    end
    return t;
  endfunction

  function automatic txn_t mk(input logic legal, input logic [31:0] baddr, input logic we,
                              input logic [3:0] strb, input logic [31:0] bwd, input int d,
                              input logic [31:0] mem, input logic [31:0] rd, input logic [1:0] f,
                              input int lat, input int runlen);
    txn_t t;
    t.legal = legal; t.baddr = baddr; t.we = we; t.strb = strb; t.bwdata = bwd;
    t.delay = d; t.rdata_mem = mem; t.exp_rdata = rd; t.exp_fault = f;
    t.lat = lat; t.runlen = runlen;
    return t;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] wd, input txn_t t);
    logic  rdy;
    resp_t r;
    in_valid = 1'b1; mem_op = op; mem_sel = sel; addr = a; wdata = wd;
    rdy = 1'b0;
    for (int g = 0; g < 40 && !rdy; g++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
    end
    chk("in_ready_wait", 32'(rdy), 32'd1);
    if (rdy && op != 2'b00) begin
      if (t.legal) bus_q.push_back(t);
      r.rdata = t.exp_rdata;
      r.fault = t.exp_fault;
      r.at_cyc = cyc + t.lat;
      resp_q.push_back(r);
    end
    in_valid = 1'b0;
    mem_op = 2'($urandom_range(0, 3));
    mem_sel = 3'($urandom_range(0, 7));
    addr = $urandom;
    wdata = $urandom;
  endtask

  // Bus responder: checks the request held stable and acks after the planned delay.
  initial begin
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rsp_active = 1'b0;
        bus_ack = 1'b0;
      end else if (bus_req) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          k_bus = 0;
          if (bus_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL bus_unexpected: bus_req=1 with nothing outstanding, expected 0");
            cur = '{default: '0};
          end else begin
            cur = bus_q.pop_front();
          end
        end
        chk("bus_addr", bus_addr, cur.baddr);
        chk("bus_we", 32'(bus_we), 32'(cur.we));
        chk("bus_wstrb", 32'(bus_wstrb), 32'(cur.strb));
        if (cur.we) chk("bus_wdata", bus_wdata, cur.bwdata);
        if (k_bus == cur.runlen) chk("bus_req_len", 32'(k_bus + 1), 32'(cur.runlen));
        bus_ack = (k_bus == cur.delay);
        bus_rdata = bus_ack ? cur.rdata_mem : $urandom;
        k_bus++;
      end else begin
        if (rsp_active) begin
          chk("bus_req_len", 32'(k_bus), 32'(cur.runlen));
          rsp_active = 1'b0;
        end
        bus_ack = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst && resp_valid) begin
        if (resp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL resp_unexpected: resp_valid=1 with nothing outstanding, expected 0");
        end else begin
          r = resp_q.pop_front();
          chk("resp_rdata", resp_rdata, r.rdata);
          chk("resp_fault", 32'(resp_fault), 32'(r.fault));
          chk("resp_cycle", 32'(cyc), 32'(r.at_cyc));
        end
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, wd, mem;
    int          s, d;
    rst = 1'b1; in_valid = 1'b0; mem_op = '0; mem_sel = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_we", 32'(bus_we), 32'd0);
    chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    issue(2'b10, 3'b001, 32'h0000_1003, 32'h0000_00A5,
          mk(1, 32'h1000, 1, 4'b1000, 32'hA5A5_A5A5, 0, 32'h0, 32'h0, 2'b00, 1, 1));
    issue(2'b01, 3'b001, 32'h0000_2001, 32'h0,
          mk(1, 32'h2000, 0, 4'b0000, 32'h0, 0, 32'h0000_F300, 32'hFFFF_FFF3, 2'b00, 1, 1));
    issue(2'b01, 3'b100, 32'h0000_2001, 32'h0,
          mk(1, 32'h2000, 0, 4'b0000, 32'h0, 0, 32'h0000_F300, 32'h0000_00F3, 2'b00, 1, 1));
    issue(2'b01, 3'b011, 32'h0000_2002, 32'h0,
          mk(0, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 32'h0, 2'b01, 0, 0));
    issue(2'b01, 3'b000, 32'h0000_2000, 32'h0,
          mk(0, 32'h0, 0, 4'b0000, 32'h0, 0, 32'h0, 32'h0, 2'b10, 0, 0));
    issue(2'b10, 3'b011, 32'h0000_3000, 32'h1234_5678,
          mk(1, 32'h3000, 1, 4'b1111, 32'h1234_5678, TO, 32'h0, 32'h0, 2'b11, TO, TO));
    issue(2'b10, 3'b011, 32'h0000_3004, 32'h8765_4321,
          mk(1, 32'h3004, 1, 4'b1111, 32'h8765_4321, TO - 1, 32'h0, 32'h0, 2'b00, TO, TO));

    // Reset in the middle of a bus access: request drops at once and no response follows.
    issue(2'b10, 3'b011, 32'h0000_4000, 32'hCAFE_F00D,
          mk(1, 32'h4000, 1, 4'b1111, 32'hCAFE_F00D, TO - 1, 32'h0, 32'h0, 2'b00, TO, TO));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_bus_req", 32'(bus_req), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    resp_q.delete();
    bus_q.delete();
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(2'b01, 3'b010, 32'h0000_5002, 32'h0,
          mk(1, 32'h5000, 0, 4'b0000, 32'h0, 1, 32'h8001_0000, 32'hFFFF_8001, 2'b00, 2, 2));

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      s = $urandom_range(0, 15);
      op = (s == 0) ? 2'b00 : (s == 1) ? 2'b11 : (s < 9) ? 2'b01 : 2'b10;
      s = $urandom_range(0, 11);
      sel = (s < 10) ? 3'((s % 5) + 1) : (s == 10) ? 3'b000 : 3'($urandom_range(6, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      wd = $urandom;
      mem = $urandom;
      d = ($urandom_range(0, 6) == 0) ? TO + $urandom_range(0, 1) : $urandom_range(0, TO - 1);
      issue(op, sel, a, wd, model(op, sel, a, wd, d, mem));
    end

    for (int i = 0; i < 100 && (resp_q.size() != 0 || rsp_active); i++) @(posedge clk);
    @(negedge clk);
    chk("drain_resp_q", 32'(resp_q.size()), 32'd0);
    chk("drain_bus_q", 32'(bus_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
